sssp_c1_wr_scheduler: RTL and testbench

//  Shares the CCI-P c1 write channel between NUM_REQ bulk writers (update-bin streams) and one status writer.

---
 rtl/sssp_c1_wr_scheduler.sv | 176 +++++++++++++++++
 tb/tb_sssp_c1_wr_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sssp_c1_wr_scheduler.sv
// sssp_c1_wr_scheduler
// Arbitrates the CCI-P c1 write channel between NUM_REQ bulk writers
// (round-robin) and one fenced status writer, and tracks outstanding writes.
module sssp_c1_wr_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        st_valid,
    input  logic [ADDR_W-1:0]           st_addr,
    input  logic [DATA_W-1:0]           st_data,
    output logic                        st_ready,
    input  logic                        c1TxAlmFull,
    output logic                        c1tx_valid,
    output logic [ADDR_W-1:0]           c1tx_addr,
    output logic [DATA_W-1:0]           c1tx_data,
    output logic [15:0]                 c1tx_mdata,
    input  logic                        c1rx_rspValid,
    output logic [6:0]                  outstanding,
    output logic [31:0]                 wr_count,
    output logic                        st_done,
    output logic                        rsp_err
);

    localparam int          PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U   = NUM_REQ;
    localparam logic [6:0]  MAX_OUT  = 7'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_FENCE,
        S_ISSUE_ST,
        S_WAIT_ST
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [6:0]          outstanding_q, outstanding_d;
    logic [31:0]         wr_count_q, wr_count_d;
    logic                c1tx_valid_q, c1tx_valid_d;
    logic [ADDR_W-1:0]   c1tx_addr_q, c1tx_addr_d;
    logic [DATA_W-1:0]   c1tx_data_q, c1tx_data_d;
    logic [15:0]         c1tx_mdata_q, c1tx_mdata_d;
    logic                st_done_q, st_done_d;
    logic                rsp_err_q, rsp_err_d;

    logic                can_issue;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic                bulk_hs;
    logic                st_hs;
    logic                rsp_counted;

    // Round-robin search for the first valid bulk requester starting at ptr_q
    always_comb begin
        int unsigned      cand;
        logic [PTR_W-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ_U) cand = cand - NREQ_U;
            cand_idx = PTR_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Ready generation: bulk only in RUN with no status pending, status only in ISSUE_ST
    always_comb begin
        req_ready = '0;
        st_ready  = 1'b0;
        can_issue = !c1TxAlmFull && (outstanding_q < MAX_OUT);
        case (state_q)
            S_RUN:      if (can_issue && !st_valid && grant_found) req_ready[grant_idx] = 1'b1;
            S_ISSUE_ST: st_ready = can_issue;
            default:    ;
        endcase
    end

    // Next-state: output register capture, counters, pointer and fence FSM
    always_comb begin
        bulk_hs       = |(req_valid & req_ready);
        st_hs         = st_valid & st_ready;
        rsp_counted   = c1rx_rspValid && (outstanding_q != '0);
        state_d       = state_q;
        ptr_d         = ptr_q;
        wr_count_d    = wr_count_q;
        outstanding_d = outstanding_q;
        c1tx_valid_d  = bulk_hs | st_hs;
        c1tx_addr_d   = c1tx_addr_q;
        c1tx_data_d   = c1tx_data_q;
        c1tx_mdata_d  = c1tx_mdata_q;
        st_done_d     = 1'b0;
        rsp_err_d     = rsp_err_q | (c1rx_rspValid && (outstanding_q == '0));

        if (bulk_hs) begin
            c1tx_addr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
            c1tx_data_d  = req_data[grant_idx*DATA_W +: DATA_W];
            c1tx_mdata_d = 16'(grant_idx);
            ptr_d        = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end else if (st_hs) begin
            c1tx_addr_d  = st_addr;
            c1tx_data_d  = st_data;
            c1tx_mdata_d = 16'hFFFF;
        end

        if (bulk_hs || st_hs) wr_count_d = wr_count_q + 32'd1;

        // A response at zero is not counted, so it can never cancel an issue
        if ((bulk_hs || st_hs) && !rsp_counted)      outstanding_d = outstanding_q + 7'd1;
        else if (!(bulk_hs || st_hs) && rsp_counted) outstanding_d = outstanding_q - 7'd1;

        case (state_q)
            S_RUN:      if (st_valid) state_d = S_FENCE;
            S_FENCE:    if ((outstanding_q == '0) && !c1tx_valid_q) state_d = S_ISSUE_ST;
            S_ISSUE_ST: if (st_hs) state_d = S_WAIT_ST;
            S_WAIT_ST: begin
                if (rsp_counted && (outstanding_q == 7'd1)) begin
                    state_d   = S_RUN;
                    st_done_d = 1'b1;
                end
            end
            default:    state_d = S_RUN;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            ptr_q         <= '0;
            outstanding_q <= '0;
            wr_count_q    <= '0;
            c1tx_valid_q  <= 1'b0;
            c1tx_addr_q   <= '0;
            c1tx_data_q   <= '0;
            c1tx_mdata_q  <= '0;
            st_done_q     <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            wr_count_q    <= wr_count_d;
            c1tx_valid_q  <= c1tx_valid_d;
            c1tx_addr_q   <= c1tx_addr_d;
            c1tx_data_q   <= c1tx_data_d;
            c1tx_mdata_q  <= c1tx_mdata_d;
            st_done_q     <= st_done_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign c1tx_valid  = c1tx_valid_q;
    assign c1tx_addr   = c1tx_addr_q;
    assign c1tx_data   = c1tx_data_q;
    assign c1tx_mdata  = c1tx_mdata_q;
    assign outstanding = outstanding_q;
    assign wr_count    = wr_count_q;
    assign st_done     = st_done_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_sssp_c1_wr_scheduler.sv
// Testbench for sssp_c1_wr_scheduler: vector table, directed fence/back-pressure/
// reset sequences, and random traffic checked against a transaction-level model.
module tb_sssp_c1_wr_scheduler;

    localparam int NREQ    = 2;
    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int MAX_OUT = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*DW-1:0]    req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  st_valid;
    logic [AW-1:0]         st_addr;
    logic [DW-1:0]         st_data;
    logic                  st_ready;
    logic                  c1TxAlmFull;
    logic                  c1tx_valid;
    logic [AW-1:0]         c1tx_addr;
    logic [DW-1:0]         c1tx_data;
    logic [15:0]           c1tx_mdata;
    logic                  c1rx_rspValid;
    logic [6:0]            outstanding;
    logic [31:0]           wr_count;
    logic                  st_done;
    logic                  rsp_err;

    sssp_c1_wr_scheduler #(
        .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .c1TxAlmFull(c1TxAlmFull),
        .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_data(c1tx_data), .c1tx_mdata(c1tx_mdata),
        .c1rx_rspValid(c1rx_rspValid),
        .outstanding(outstanding), .wr_count(wr_count), .st_done(st_done), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transaction-level reference: protocol phase, RR pointer, counters, last issued line
    typedef enum {PH_RUN, PH_FENCE, PH_ISSUE, PH_WAIT} ph_t;
    ph_t         m_ph;
    int          m_ptr, m_out;
    logic [31:0] m_wr;
    logic        m_v, m_done, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [15:0]   m_md;

    logic [NREQ-1:0] obs_rdy;
    logic            obs_st, obs_v, obs_done;
    logic [AW-1:0]   obs_addr;
    logic [15:0]     obs_md;

    function automatic void model_reset();
        m_ph = PH_RUN; m_ptr = 0; m_out = 0; m_wr = '0; m_v = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0; m_md = '0;
    endfunction

    // One clock cycle: check readies mid-cycle, advance model, check registered outputs
    task automatic step();
        logic [NREQ-1:0] e_rdy;
        logic            e_st, r, sv, done, hs;
        int              g;
        bit              can;
        logic [AW-1:0]   n_addr;
        logic [DW-1:0]   n_data;
        logic [15:0]     n_md;
        g = -1; e_rdy = '0; e_st = 1'b0; hs = 1'b0; done = 1'b0;
        n_addr = m_addr; n_data = m_data; n_md = m_md;
        @(negedge clk);
        obs_rdy = req_ready;
        obs_st  = st_ready;
        r  = c1rx_rspValid;
        sv = st_valid;
        can = !c1TxAlmFull && (m_out < MAX_OUT);
        if (m_ph == PH_RUN && !sv && can) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        if (m_ph == PH_ISSUE) e_st = can;
        if (g >= 0) e_rdy[g] = 1'b1;
        if (!reset) begin
            chk("req_ready", 64'(req_ready), 64'(e_rdy));
            chk("st_ready", 64'(st_ready), 64'(e_st));
        end
        if (g >= 0) begin
            hs = 1'b1; n_addr = req_addr[g*AW +: AW]; n_data = req_data[g*DW +: DW]; n_md = 16'(g);
        end else if (e_st && sv) begin
            hs = 1'b1; n_addr = st_addr; n_data = st_data; n_md = 16'hFFFF;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            case (m_ph)
                PH_RUN:   if (sv) m_ph = PH_FENCE;
                PH_FENCE: if (m_out == 0 && !m_v) m_ph = PH_ISSUE;
                PH_ISSUE: if (e_st && sv) m_ph = PH_WAIT;
                PH_WAIT:  if (r && m_out == 1) begin m_ph = PH_RUN; done = 1'b1; end
                default:  m_ph = PH_RUN;
            endcase
            if (r && m_out == 0) m_err = 1'b1;
            m_out = m_out + (hs ? 1 : 0) - ((r && m_out > 0) ? 1 : 0);
            if (hs) m_wr = m_wr + 32'd1;
            if (g >= 0) m_ptr = (g + 1) % NREQ;
            m_v = hs; m_addr = n_addr; m_data = n_data; m_md = n_md; m_done = done;
        end
        chk("c1tx_valid", 64'(c1tx_valid), 64'(m_v));
        if (m_v) begin
            chk("c1tx_addr", 64'(c1tx_addr), 64'(m_addr));
            chk("c1tx_data", 64'(c1tx_data), 64'(m_data));
            chk("c1tx_mdata", 64'(c1tx_mdata), 64'(m_md));
        end
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("wr_count", 64'(wr_count), 64'(m_wr));
        chk("st_done", 64'(st_done), 64'(m_done));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        obs_v = c1tx_valid; obs_addr = c1tx_addr; obs_md = c1tx_mdata; obs_done = st_done;
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic        alm;
        logic        rsp;
        logic [1:0]  e_rdy;
        logic        e_v;
        logic [15:0] e_md;
        logic [6:0]  e_out;
        logic [31:0] e_wr;
        logic        e_err;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [1:0] rv, input logic alm, input logic rsp,
                                input logic [1:0] e_rdy, input logic e_v, input logic [15:0] e_md,
                                input logic [6:0] e_out, input logic [31:0] e_wr, input logic e_err);
        vec_t v;
        v.rv = rv; v.alm = alm; v.rsp = rsp; v.e_rdy = e_rdy; v.e_v = e_v;
        v.e_md = e_md; v.e_out = e_out; v.e_wr = e_wr; v.e_err = e_err;
        tbl.push_back(v);
    endfunction

    task automatic idle_inputs();
        req_valid = '0; st_valid = 1'b0; c1TxAlmFull = 1'b0; c1rx_rspValid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] lines[$];

    initial begin
        int sent, cyc;
        bit seen;
        reset = 1'b1;
        idle_inputs();
        req_addr = '0; req_data = '0; st_addr = '0; st_data = '0;
        model_reset();
        obs_rdy = '0; obs_st = 1'b0; obs_v = 1'b0; obs_done = 1'b0; obs_addr = '0; obs_md = '0;

        // Reset state
        do_reset();
        chk("reset_c1tx_valid", 64'(c1tx_valid), 64'd0);
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_wr_count", 64'(wr_count), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);

        // RR fairness, outstanding limit, simultaneous issue+rsp, spurious rsp, alm gate
        for (int k = 0; k < 8; k++)
            add(2'b11, 0, (k >= 1), (k % 2 == 0) ? 2'b01 : 2'b10, 1, 16'(k % 2), 7'd1, 32'(k + 1), 0);
        add(2'b00, 0, 1, 2'b00, 0, 16'd0, 7'd0, 32'd8, 0);
        add(2'b01, 0, 0, 2'b01, 1, 16'd0, 7'd1, 32'd9, 0);
        add(2'b01, 0, 0, 2'b01, 1, 16'd0, 7'd2, 32'd10, 0);
        add(2'b01, 0, 0, 2'b01, 1, 16'd0, 7'd3, 32'd11, 0);
        add(2'b01, 0, 0, 2'b01, 1, 16'd0, 7'd4, 32'd12, 0);
        add(2'b01, 0, 0, 2'b00, 0, 16'd0, 7'd4, 32'd12, 0);
        add(2'b01, 0, 0, 2'b00, 0, 16'd0, 7'd4, 32'd12, 0);
        add(2'b01, 0, 1, 2'b00, 0, 16'd0, 7'd3, 32'd12, 0);
        add(2'b01, 0, 0, 2'b01, 1, 16'd0, 7'd4, 32'd13, 0);
        add(2'b01, 0, 0, 2'b00, 0, 16'd0, 7'd4, 32'd13, 0);
        add(2'b00, 0, 1, 2'b00, 0, 16'd0, 7'd3, 32'd13, 0);
        add(2'b01, 0, 1, 2'b01, 1, 16'd0, 7'd3, 32'd14, 0);
        add(2'b00, 0, 1, 2'b00, 0, 16'd0, 7'd2, 32'd14, 0);
        add(2'b00, 0, 1, 2'b00, 0, 16'd0, 7'd1, 32'd14, 0);
        add(2'b00, 0, 1, 2'b00, 0, 16'd0, 7'd0, 32'd14, 0);
        add(2'b00, 0, 1, 2'b00, 0, 16'd0, 7'd0, 32'd14, 1);
        add(2'b10, 0, 0, 2'b10, 1, 16'd1, 7'd1, 32'd15, 1);
        add(2'b11, 0, 1, 2'b01, 1, 16'd0, 7'd1, 32'd16, 1);
        add(2'b01, 1, 0, 2'b00, 0, 16'd0, 7'd1, 32'd16, 1);
        add(2'b01, 0, 1, 2'b01, 1, 16'd0, 7'd1, 32'd17, 1);

        foreach (tbl[i]) begin
            req_valid = tbl[i].rv; c1TxAlmFull = tbl[i].alm; c1rx_rspValid = tbl[i].rsp;
            req_addr = $urandom; req_data = {$urandom, $urandom};
            step();
            chk($sformatf("tbl%0d_ready", i), 64'(obs_rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(obs_v), 64'(tbl[i].e_v));
            if (tbl[i].e_v) chk($sformatf("tbl%0d_mdata", i), 64'(obs_md), 64'(tbl[i].e_md));
            chk($sformatf("tbl%0d_out", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("tbl%0d_wr", i), 64'(wr_count), 64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_err", i), 64'(rsp_err), 64'(tbl[i].e_err));
        end

        // Back-pressure during a 10-line burst: AlmFull in cycles 3..6
        do_reset();
        lines.delete();
        sent = 0;
        for (cyc = 0; cyc < 40 && lines.size() < 10; cyc++) begin
            req_valid = (sent < 10) ? 2'b01 : 2'b00;
            req_addr = {16'h0, 16'(sent)};
            req_data = {32'h0, 32'(sent * 3 + 1)};
            c1TxAlmFull = (cyc >= 3 && cyc <= 6);
            c1rx_rspValid = (m_out > 0);
            step();
            if (obs_rdy[0] && req_valid[0]) sent++;
            if (cyc >= 3 && cyc <= 6) chk("bp_gap_valid", 64'(obs_v), 64'd0);
            if (obs_v) lines.push_back(obs_addr);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            c1rx_rspValid = (m_out > 0);
            step();
            if (obs_v) lines.push_back(obs_addr);
        end
        chk("bp_line_count", 64'(lines.size()), 64'd10);
        foreach (lines[i]) chk($sformatf("bp_line%0d_addr", i), 64'(lines[i]), 64'(i));

        // Fence: status waits until every earlier bulk write is acknowledged
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b01; req_addr = 32'(16'h100 + k); req_data = $urandom;
            step();
        end
        req_valid = '0;
        st_valid = 1'b1; st_addr = 16'hABCD; st_data = 32'h5A5A_1234;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fence_st_ready_hold", 64'(obs_st), 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            c1rx_rspValid = 1'b1;
            step();
            chk("fence_st_ready_rsp", 64'(obs_st), 64'd0);
        end
        c1rx_rspValid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = obs_st;
        end
        chk("fence_st_granted", 64'(seen), 64'd1);
        chk("fence_st_valid_out", 64'(obs_v), 64'd1);
        chk("fence_st_mdata", 64'(obs_md), 64'hFFFF);
        chk("fence_st_addr", 64'(obs_addr), 64'hABCD);
        st_valid = 1'b0;
        step();
        chk("fence_no_done_early", 64'(obs_done), 64'd0);
        c1rx_rspValid = 1'b1;
        step();
        chk("fence_st_done_pulse", 64'(obs_done), 64'd1);
        c1rx_rspValid = 1'b0;
        step();
        chk("fence_st_done_clear", 64'(obs_done), 64'd0);

        // Reset while waiting for the status response
        st_valid = 1'b1; st_addr = 16'h0777;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = obs_st;
        end
        chk("rst_st_granted", 64'(seen), 64'd1);
        st_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_c1tx_valid", 64'(c1tx_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        c1rx_rspValid = 1'b1;
        step();
        chk("rst_stale_rsp_err", 64'(rsp_err), 64'd1);
        chk("rst_stale_rsp_out", 64'(outstanding), 64'd0);
        c1rx_rspValid = 1'b0;
        req_valid = 2'b01;
        step();
        chk("rst_run_grant", 64'(obs_rdy), 64'd1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            req_valid = NREQ'($urandom);
            req_addr = $urandom;
            req_data = {$urandom, $urandom};
            c1TxAlmFull = ($urandom_range(0, 4) == 0);
            c1rx_rspValid = (m_out > 0) && ($urandom_range(0, 2) == 0);
            if (!st_valid && m_ph == PH_RUN && $urandom_range(0, 24) == 0) begin
                st_valid = 1'b1; st_addr = AW'($urandom); st_data = $urandom;
            end
            step();
            if (obs_st && st_valid) st_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
